turn_controller: RTL and testbench

- Parametrised turn sequencer for the board-game datapath; successor to the single-board select-box controller.
- Owns the cursor, with rate-limited auto-repeat and edge clamping.
- Sequences piece pick, destination pick and deselect for N players.
- Hands each candidate square to an external rule checker over a req/ack handshake, then either commits the move or ends the game.

---
 rtl/turn_controller_if.sv | 24 ++
 rtl/turn_controller.sv | 209 ++++++++++++++++++++
 tb/tb_turn_controller.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/turn_controller_if.sv
// Checker handshake bundle between the turn controller and the external
// rule checker.
//   chk_req  : controller -> checker, level request, held until chk_ack
//   chk_kind : controller -> checker, 0 = piece check, 1 = destination check
//   chk_ack  : checker -> controller, response valid
//   chk_ok   : checker -> controller, candidate legal (with chk_ack)
//   chk_win  : checker -> controller, committed move wins (with chk_ack, kind 1)
interface turn_controller_if;
   logic chk_req;
   logic chk_kind;
   logic chk_ack;
   logic chk_ok;
   logic chk_win;

   modport master (
      output chk_req, chk_kind,
      input  chk_ack, chk_ok, chk_win
   );

   modport slave (
      input  chk_req, chk_kind,
      output chk_ack, chk_ok, chk_win
   );
endinterface

// File: rtl/turn_controller.sv
// Turn sequencer for the board-game datapath. Owns the cursor (auto-repeat,
// clamped at the board edges), sequences piece pick / destination pick /
// deselect for NUM_PLAYERS players, and asks the external rule checker about
// each candidate square before committing the move or ending the game.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   up/down/left/right      direction buttons (level, pre-synchronised)
//   select, deselect        buttons (level, pre-synchronised, edge-detected here)
//   chk                     checker handshake (master side)
//   cursor_x/y              cursor, (0,0) bottom-left
//   piece_x/y, move_x/y     latched source / destination squares
//   cur_player              player to move
//   commit                  one-cycle pulse on an accepted move
//   game_over, winner       game finished / winning player
//   state                   FSM state code
//
// state      | meaning
// IDLE  (0)  | no game running, cursor parked at (0,0)
// PICK  (1)  | player chooses the piece to move
// WAIT_PIECE | piece check outstanding (chk_req, kind 0)
// DEST  (3)  | player chooses the destination square
// WAIT_DEST  | destination check outstanding (chk_req, kind 1)
// OVER  (5)  | game finished, waiting for select to return to IDLE
module turn_controller #(
   parameter int BOARD_W     = 8,
   parameter int BOARD_H     = 8,
   parameter int COORD_W     = 4,
   parameter int NUM_PLAYERS = 2,
   parameter int PLAYER_W    = 1,
   parameter int REPEAT_DIV  = 12500000,
   parameter int DIV_W       = 24
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                up,
   input  logic                down,
   input  logic                left,
   input  logic                right,
   input  logic                select,
   input  logic                deselect,
   turn_controller_if.master   chk,
   output logic [COORD_W-1:0]  cursor_x,
   output logic [COORD_W-1:0]  cursor_y,
   output logic [COORD_W-1:0]  piece_x,
   output logic [COORD_W-1:0]  piece_y,
   output logic [COORD_W-1:0]  move_x,
   output logic [COORD_W-1:0]  move_y,
   output logic [PLAYER_W-1:0] cur_player,
   output logic                commit,
   output logic                game_over,
   output logic [PLAYER_W-1:0] winner,
   output logic [2:0]          state
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_PICK       = 3'd1,
      S_WAIT_PIECE = 3'd2,
      S_DEST       = 3'd3,
      S_WAIT_DEST  = 3'd4,
      S_OVER       = 3'd5
   } state_t;

   state_t st;

   logic sel_q, desel_q;
   logic sel_edge, desel_edge;
   logic [DIV_W-1:0] rep_cnt;
   logic [COORD_W-1:0] next_x, next_y;
   logic move_en, any_dir, step;

   assign move_en = (st == S_PICK) || (st == S_DEST);
   assign any_dir = up | down | left | right;
   // Step on the first enabled cycle of a hold, then each time the
   // down-counter reaches its terminal count.
   assign step    = move_en && any_dir && (rep_cnt == '0);

   always_comb begin
      next_x = cursor_x;
      next_y = cursor_y;
      if (step) begin
         if (up && !down && cursor_y != COORD_W'(BOARD_H - 1))
            next_y = cursor_y + COORD_W'(1);
         if (down && !up && cursor_y != '0)
            next_y = cursor_y - COORD_W'(1);
         if (right && !left && cursor_x != COORD_W'(BOARD_W - 1))
            next_x = cursor_x + COORD_W'(1);
         if (left && !right && cursor_x != '0)
            next_x = cursor_x - COORD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st           <= S_IDLE;
         sel_q        <= 1'b0;
         desel_q      <= 1'b0;
         sel_edge     <= 1'b0;
         desel_edge   <= 1'b0;
         rep_cnt      <= '0;
         cursor_x     <= '0;
         cursor_y     <= '0;
         piece_x      <= '0;
         piece_y      <= '0;
         move_x       <= '0;
         move_y       <= '0;
         cur_player   <= '0;
         commit       <= 1'b0;
         game_over    <= 1'b0;
         winner       <= '0;
         chk.chk_req  <= 1'b0;
         chk.chk_kind <= 1'b0;
      end else begin
         // Edges are registered so the FSM sees them one cycle after the raw rise.
         sel_q      <= select;
         desel_q    <= deselect;
         sel_edge   <= select & ~sel_q;
         desel_edge <= deselect & ~desel_q;
         commit     <= 1'b0;

         if (!move_en || !any_dir)
            rep_cnt <= '0;
         else if (rep_cnt == '0)
            rep_cnt <= DIV_W'(REPEAT_DIV - 1);
         else
            rep_cnt <= rep_cnt - DIV_W'(1);

         if (move_en) begin
            cursor_x <= next_x;
            cursor_y <= next_y;
         end

         case (st)
            S_IDLE: begin
               if (sel_edge) st <= S_PICK;
            end
            S_PICK: begin
               if (sel_edge) begin
                  piece_x      <= cursor_x;
                  piece_y      <= cursor_y;
                  chk.chk_req  <= 1'b1;
                  chk.chk_kind <= 1'b0;
                  st           <= S_WAIT_PIECE;
               end
            end
            S_WAIT_PIECE: begin
               if (chk.chk_ack) begin
                  chk.chk_req <= 1'b0;
                  st          <= chk.chk_ok ? S_DEST : S_PICK;
               end
            end
            S_DEST: begin
               if (desel_edge) begin
                  st <= S_PICK;
               end else if (sel_edge) begin
                  // Selecting the picked piece again behaves as a deselect.
                  if (cursor_x == piece_x && cursor_y == piece_y) begin
                     st <= S_PICK;
                  end else begin
                     move_x       <= cursor_x;
                     move_y       <= cursor_y;
                     chk.chk_req  <= 1'b1;
                     chk.chk_kind <= 1'b1;
                     st           <= S_WAIT_DEST;
                  end
               end
            end
            S_WAIT_DEST: begin
               if (chk.chk_ack) begin
                  chk.chk_req <= 1'b0;
                  if (!chk.chk_ok) begin
                     st <= S_DEST;
                  end else begin
                     commit <= 1'b1;
                     if (chk.chk_win) begin
                        game_over <= 1'b1;
                        winner    <= cur_player;
                        st        <= S_OVER;
                     end else begin
                        cur_player <= (cur_player == PLAYER_W'(NUM_PLAYERS - 1)) ?
                                      '0 : cur_player + PLAYER_W'(1);
                        st         <= S_PICK;
                     end
                  end
               end
            end
            S_OVER: begin
               if (sel_edge) begin
                  st         <= S_IDLE;
                  game_over  <= 1'b0;
                  winner     <= '0;
                  cur_player <= '0;
                  piece_x    <= '0;
                  piece_y    <= '0;
                  move_x     <= '0;
                  move_y     <= '0;
                  cursor_x   <= '0;
                  cursor_y   <= '0;
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end

   assign state = st;

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: directed walk through the turn sequence followed
// by randomized button/checker traffic. A reference model predicts each
// cycle's outputs plus the request and commit transactions; a monitor process
// compares the DUT against those queues.
module tb_turn_controller;
   localparam int BOARD_W     = 8;
   localparam int BOARD_H     = 8;
   localparam int COORD_W     = 4;
   localparam int NUM_PLAYERS = 3;
   localparam int PLAYER_W    = 2;
   localparam int REPEAT_DIV  = 4;
   localparam int DIV_W       = 3;

   localparam int M_IDLE = 0, M_PICK = 1, M_WAIT_P = 2, M_DEST = 3, M_WAIT_D = 4, M_OVER = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
   logic select = 1'b0, deselect = 1'b0;
   logic [COORD_W-1:0] cursor_x, cursor_y, piece_x, piece_y, move_x, move_y;
   logic [PLAYER_W-1:0] cur_player, winner;
   logic commit, game_over;
   logic [2:0] state;

   turn_controller_if chk_bus();

   turn_controller #(
      .BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .COORD_W(COORD_W),
      .NUM_PLAYERS(NUM_PLAYERS), .PLAYER_W(PLAYER_W),
      .REPEAT_DIV(REPEAT_DIV), .DIV_W(DIV_W)
   ) dut (
      .clk(clk), .reset(reset),
      .up(up), .down(down), .left(left), .right(right),
      .select(select), .deselect(deselect),
      .chk(chk_bus),
      .cursor_x(cursor_x), .cursor_y(cursor_y),
      .piece_x(piece_x), .piece_y(piece_y),
      .move_x(move_x), .move_y(move_y),
      .cur_player(cur_player), .commit(commit),
      .game_over(game_over), .winner(winner), .state(state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct { int kind; int x; int y; } req_t;
   typedef struct { int x; int y; int pl; bit over; } com_t;
   typedef struct {
      int st, cx, cy, px, py, mx, my, pl, win;
      bit over, req;
   } snap_t;

   req_t  req_q[$];
   com_t  com_q[$];
   snap_t snap_q[$];

   // reference model state (game-level view)
   int m_st = M_IDLE, m_cx = 0, m_cy = 0, m_px = 0, m_py = 0, m_mx = 0, m_my = 0;
   int m_pl = 0, m_win = 0, m_hold = 0;
   bit m_over = 0;
   bit s_h1 = 0, s_h2 = 0, d_h1 = 0, d_h2 = 0;

   // bench-driven inputs
   bit b_rst = 1, b_u = 0, b_d = 0, b_l = 0, b_r = 0, b_sel = 0, b_des = 0;
   bit b_ack = 0, b_ok = 0, b_win = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit rst, input bit u, input bit d, input bit l, input bit r,
                             input bit s, input bit ds, input bit ack, input bit ok, input bit win);
      bit se, de, en;
      int ox, oy;
      se = s_h1 && !s_h2;
      de = d_h1 && !d_h2;
      ox = m_cx;
      oy = m_cy;
      if (rst) begin
         m_st = M_IDLE; m_cx = 0; m_cy = 0; m_px = 0; m_py = 0; m_mx = 0; m_my = 0;
         m_pl = 0; m_win = 0; m_over = 0; m_hold = 0;
         s_h1 = 0; s_h2 = 0; d_h1 = 0; d_h2 = 0;
         return;
      end
      s_h2 = s_h1; s_h1 = s;
      d_h2 = d_h1; d_h1 = ds;
      en = (m_st == M_PICK) || (m_st == M_DEST);
      if (en && (u || d || l || r)) begin
         if (m_hold % REPEAT_DIV == 0) begin
            if (u && !d && oy < BOARD_H - 1) m_cy = oy + 1;
            if (d && !u && oy > 0)           m_cy = oy - 1;
            if (r && !l && ox < BOARD_W - 1) m_cx = ox + 1;
            if (l && !r && ox > 0)           m_cx = ox - 1;
         end
         m_hold++;
      end else begin
         m_hold = 0;
      end
      case (m_st)
         M_IDLE: if (se) m_st = M_PICK;
         M_PICK: if (se) begin
            m_px = ox; m_py = oy;
            req_q.push_back('{0, ox, oy});
            m_st = M_WAIT_P;
         end
         M_WAIT_P: if (ack) m_st = ok ? M_DEST : M_PICK;
         M_DEST: begin
            if (de) m_st = M_PICK;
            else if (se) begin
               if (ox == m_px && oy == m_py) m_st = M_PICK;
               else begin
                  m_mx = ox; m_my = oy;
                  req_q.push_back('{1, ox, oy});
                  m_st = M_WAIT_D;
               end
            end
         end
         M_WAIT_D: if (ack) begin
            if (!ok) m_st = M_DEST;
            else begin
               if (win) begin
                  m_over = 1; m_win = m_pl; m_st = M_OVER;
               end else begin
                  m_pl = (m_pl + 1) % NUM_PLAYERS; m_st = M_PICK;
               end
               com_q.push_back('{m_mx, m_my, m_pl, m_over});
            end
         end
         M_OVER: if (se) begin
            m_st = M_IDLE; m_over = 0; m_win = 0; m_pl = 0;
            m_px = 0; m_py = 0; m_mx = 0; m_my = 0; m_cx = 0; m_cy = 0;
         end
         default: m_st = M_IDLE;
      endcase
   endtask

   // One clock: drive inputs on the falling edge, predict, then return just
   // after the rising edge so directed checks see the updated DUT.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset = b_rst; up = b_u; down = b_d; left = b_l; right = b_r;
         select = b_sel; deselect = b_des;
         chk_bus.chk_ack = b_ack; chk_bus.chk_ok = b_ok; chk_bus.chk_win = b_win;
         model_step(b_rst, b_u, b_d, b_l, b_r, b_sel, b_des, b_ack, b_ok, b_win);
         snap_q.push_back('{m_st, m_cx, m_cy, m_px, m_py, m_mx, m_my, m_pl, m_win, m_over,
                            (m_st == M_WAIT_P) || (m_st == M_WAIT_D)});
         @(posedge clk);
         #2;
      end
   endtask

   task automatic press(input bit s, input bit ds);
      b_sel = s; b_des = ds; tick(1);
      b_sel = 0; b_des = 0;  tick(1);
   endtask

   task automatic respond(input bit ok, input bit win);
      b_ack = 1; b_ok = ok; b_win = win; tick(1);
      b_ack = 0; b_ok = 0;  b_win = 0;
   endtask

   task automatic nudge(input int dir);
      b_u = (dir == 0); b_d = (dir == 1); b_l = (dir == 2); b_r = (dir == 3);
      tick(1);
      b_u = 0; b_d = 0; b_l = 0; b_r = 0;
      tick(1);
   endtask

   task automatic to_dest();
      press(1, 0);
      respond(1, 0);
   endtask

   task automatic do_turn(input bit win);
      to_dest();
      nudge(m_cy > 0 ? 1 : 0);
      press(1, 0);
      respond(1, win);
   endtask

   // monitor / scoreboard
   initial begin
      bit req_prev;
      snap_t s;
      req_t rq;
      com_t cm;
      req_prev = 0;
      chk_bus.chk_ack = 0; chk_bus.chk_ok = 0; chk_bus.chk_win = 0;
      forever begin
         @(posedge clk);
         #1;
         if (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            check("state",      int'(state),      s.st);
            check("cursor_x",   int'(cursor_x),   s.cx);
            check("cursor_y",   int'(cursor_y),   s.cy);
            check("piece_x",    int'(piece_x),    s.px);
            check("piece_y",    int'(piece_y),    s.py);
            check("move_x",     int'(move_x),     s.mx);
            check("move_y",     int'(move_y),     s.my);
            check("cur_player", int'(cur_player), s.pl);
            check("winner",     int'(winner),     s.win);
            check("game_over",  int'(game_over),  int'(s.over));
            check("chk_req",    int'(chk_bus.chk_req), int'(s.req));
         end
         if (chk_bus.chk_req === 1'b1 && !req_prev) begin
            if (req_q.size() == 0) check("unexpected_req", 1, 0);
            else begin
               rq = req_q.pop_front();
               check("req_kind", int'(chk_bus.chk_kind), rq.kind);
               check("req_x", rq.kind ? int'(move_x) : int'(piece_x), rq.x);
               check("req_y", rq.kind ? int'(move_y) : int'(piece_y), rq.y);
            end
         end
         req_prev = (chk_bus.chk_req === 1'b1);
         if (commit === 1'b1) begin
            if (com_q.size() == 0) check("unexpected_commit", 1, 0);
            else begin
               cm = com_q.pop_front();
               check("commit_move_x", int'(move_x), cm.x);
               check("commit_move_y", int'(move_y), cm.y);
               check("commit_player", int'(cur_player), cm.pl);
               check("commit_over",   int'(game_over), int'(cm.over));
            end
         end
      end
   end

   // stimulus
   initial begin
      int wait_cnt, delay;
      b_rst = 1; tick(2);
      b_rst = 0; tick(1);
      check("reset_state", int'(state), 0);
      check("reset_req", int'(chk_bus.chk_req), 0);

      press(1, 0);
      check("idle_to_pick", int'(state), 1);

      b_u = 1; tick(3 * REPEAT_DIV + 1); b_u = 0;
      check("repeat_y", int'(cursor_y), 4);
      check("repeat_x", int'(cursor_x), 0);
      tick(1);
      b_d = 1; tick(20); b_d = 0;
      check("clamp_y0", int'(cursor_y), 0);
      tick(1);

      nudge(3); nudge(3); nudge(0);
      press(1, 0);
      check("piece_req", int'(chk_bus.chk_req), 1);
      respond(1, 0);
      check("piece_ok_dest", int'(state), 3);
      check("piece_x", int'(piece_x), 2);
      check("piece_y", int'(piece_y), 1);

      press(0, 1);
      check("deselect_pick", int'(state), 1);
      press(1, 0);
      respond(0, 0);
      check("piece_bad_pick", int'(state), 1);

      to_dest();
      nudge(0); nudge(0);
      press(1, 0);
      check("dest_kind", int'(chk_bus.chk_kind), 1);
      respond(1, 0);
      check("move_x", int'(move_x), 2);
      check("move_y", int'(move_y), 3);
      check("player_after_1", int'(cur_player), 1);

      to_dest();
      press(1, 0);
      check("reselect_piece", int'(state), 1);
      to_dest();
      press(0, 1);
      check("dest_deselect", int'(state), 1);
      to_dest();
      press(1, 1);
      check("both_edges", int'(state), 1);

      do_turn(0);
      check("player_after_2", int'(cur_player), 2);
      do_turn(0);
      check("player_wrap", int'(cur_player), 0);
      do_turn(0);
      do_turn(1);
      check("win_over", int'(game_over), 1);
      check("win_winner", int'(winner), 1);
      check("win_state", int'(state), 5);
      b_u = 1; tick(6); b_u = 0;
      press(0, 1);
      check("over_ignores", int'(state), 5);
      press(1, 0);
      check("over_idle", int'(state), 0);
      check("over_clear_go", int'(game_over), 0);
      check("over_clear_player", int'(cur_player), 0);
      check("over_clear_cursor", int'(cursor_x) + int'(cursor_y), 0);

      press(1, 0);
      to_dest();
      nudge(0);
      press(1, 0);
      tick(2);
      check("wait_dest_req", int'(chk_bus.chk_req), 1);
      b_rst = 1; tick(1); b_rst = 0;
      check("rst_drop_req", int'(chk_bus.chk_req), 0);
      check("rst_idle", int'(state), 0);
      respond(1, 1);
      check("late_ack_ignored", int'(state), 0);

      wait_cnt = 0;
      delay = $urandom_range(0, 3);
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 9) == 0) b_u = ~b_u;
         if ($urandom_range(0, 9) == 0) b_d = ~b_d;
         if ($urandom_range(0, 9) == 0) b_l = ~b_l;
         if ($urandom_range(0, 9) == 0) b_r = ~b_r;
         if ($urandom_range(0, 2) == 0) b_sel = ~b_sel;
         if ($urandom_range(0, 7) == 0) b_des = ~b_des;
         b_rst = ($urandom_range(0, 399) == 0);
         if (m_st == M_WAIT_P || m_st == M_WAIT_D) begin
            if (wait_cnt >= delay) begin
               b_ack = 1;
               b_ok = ($urandom_range(0, 9) < 7);
               b_win = ($urandom_range(0, 3) == 0);
               delay = $urandom_range(0, 3);
               wait_cnt = 0;
            end else begin
               b_ack = 0;
               wait_cnt++;
            end
         end else begin
            b_ack = ($urandom_range(0, 15) == 0);
            b_ok = $urandom_range(0, 1);
            b_win = $urandom_range(0, 1);
            wait_cnt = 0;
         end
         tick(1);
      end
      b_rst = 0; b_ack = 0; b_sel = 0; b_des = 0; b_u = 0; b_d = 0; b_l = 0; b_r = 0;
      tick(3);
      check("req_queue_drained", req_q.size(), 0);
      check("commit_queue_drained", com_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
